// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types for the SRAM bus arbiter: FSM states, access owner and starvation counter helpers.
package sram_bus_arbiter_pkg;

  localparam int ADDR_W_DEF       = 21;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_W         = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_RD2  = 3'd2,
    ST_WR1  = 3'd3,
    ST_WR2  = 3'd4,
    ST_WR3  = 3'd5,
    ST_DONE = 3'd6
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_t;

  function automatic logic [STARVE_W-1:0] starve_sat_inc(input logic [STARVE_W-1:0] cnt,
                                                         input int limit);
    if (cnt >= STARVE_W'(limit)) return STARVE_W'(limit);
    return cnt + 1'b1;
  endfunction

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// Bus bundle between pipeline IF/MEM requesters, the arbiter and the SRAM driver.
interface sram_bus_arbiter_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              stall_req;

  logic              ram_en;
  logic              ram_re;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ack,
    output if_rdata, if_ack, mem_rdata, mem_ack, stall_req,
    output ram_en, ram_re, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ack,
    input  if_rdata, if_ack, mem_rdata, mem_ack, stall_req,
    input  ram_en, ram_re, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/sram_bus_arbiter_pick.sv
// Combinational grant: MEM has priority unless IF has been passed over STARVE_LIMIT times.
// Zero latency; at most one grant asserted.
module sram_bus_arbiter_pick #(
  parameter int STARVE_W     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                i_if_req,
  input  logic                i_mem_req,
  input  logic [STARVE_W-1:0] i_starve_cnt,
  output logic                o_grant_if,
  output logic                o_grant_mem
);

  logic w_starved;

  assign w_starved   = (i_starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign o_grant_if  = i_if_req & (~i_mem_req | w_starved);
  assign o_grant_mem = i_mem_req & ~o_grant_if;

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM driver port between IF (read-only) and MEM (read/write).
// Read: 4 cycles req-to-ack inclusive; write: 5 + driver busy cycles. Requesters stall while waiting.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sram_bus_arbiter_if.slave  bus
);

  arb_state_t          r_state;
  owner_t              r_owner;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic                r_ram_en;
  logic                r_ram_re;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_mem_rdata;
  logic                r_if_ack;
  logic                r_mem_ack;

  logic                w_grant_if;
  logic                w_grant_mem;

  sram_bus_arbiter_pick #(
    .STARVE_W     (STARVE_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .i_if_req     (bus.if_req),
    .i_mem_req    (bus.mem_req),
    .i_starve_cnt (r_starve_cnt),
    .o_grant_if   (w_grant_if),
    .o_grant_mem  (w_grant_mem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_NONE;
      r_starve_cnt <= '0;
      r_ram_en     <= 1'b0;
      r_ram_re     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_if_rdata   <= '0;
      r_mem_rdata  <= '0;
      r_if_ack     <= 1'b0;
      r_mem_ack    <= 1'b0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_if) begin
            r_owner      <= OWN_IF;
            r_ram_addr   <= bus.if_addr;
            r_ram_en     <= 1'b1;
            r_ram_re     <= 1'b1;
            r_ram_we     <= 1'b0;
            r_starve_cnt <= '0;
            r_state      <= ST_RD1;
          end else if (w_grant_mem) begin
            r_owner      <= OWN_MEM;
            r_ram_addr   <= bus.mem_addr;
            r_ram_wdata  <= bus.mem_wdata;
            r_ram_en     <= 1'b1;
            r_ram_re     <= ~bus.mem_we;
            r_ram_we     <= bus.mem_we;
            // Only a MEM grant that actually bypasses a waiting IF counts toward starvation.
            r_starve_cnt <= bus.if_req ? starve_sat_inc(r_starve_cnt, STARVE_LIMIT) : '0;
            r_state      <= bus.mem_we ? ST_WR1 : ST_RD1;
          end
        end
        ST_RD1: begin
          r_ram_en <= 1'b0;
          r_ram_re <= 1'b0;
          r_state  <= ST_RD2;
        end
        ST_RD2: begin
          if (r_owner == OWN_IF) begin
            r_if_rdata <= bus.ram_rdata;
            r_if_ack   <= 1'b1;
          end else begin
            r_mem_rdata <= bus.ram_rdata;
            r_mem_ack   <= 1'b1;
          end
          r_state <= ST_DONE;
        end
        ST_WR1: begin
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          r_state  <= ST_WR2;
        end
        ST_WR2: r_state <= ST_WR3;
        ST_WR3: begin
          if (bus.ram_ack) begin
            r_mem_ack <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_owner <= OWN_NONE;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ram_en    = r_ram_en;
  assign bus.ram_re    = r_ram_re;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.mem_ack   = r_mem_ack;
  assign bus.stall_req = (bus.if_req & ~r_if_ack) | (bus.mem_req & ~r_mem_ack);

endmodule
